snake_frame_scanner: RTL and testbench

- Incremental frame-update controller for the snake game image generator.
- Raster-scans a 16x12 cell grid and presents each cell's (x,y) to the upstream game logic, which returns object flags.
- Encodes the flags into a 3-bit object code and compares it with a stored copy of the last drawn frame.
- Only changed cells are handed to the display command engine, one at a time, under a diff/cmd_done handshake.

---
 rtl/snake_frame_scanner.sv | 137 +++++++++++++
 tb/tb_snake_frame_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_scanner.sv
// Incremental frame-update controller: raster-scans the cell grid, diffs each cell's
// object code against the last drawn frame and hands changed cells to the display engine.
module snake_frame_scanner #(
   parameter int GRID_W = 16,
   parameter int GRID_H = 12
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       snakeBody,
   input  logic       snakeHead,
   input  logic       apple,
   input  logic       border,
   input  logic       mode_pb,
   input  logic       GameOver,
   input  logic       cmd_done,
   output logic       enable_loop,
   output logic       diff,
   output logic       init_cycle,
   output logic       en_update,
   output logic       sync_reset,
   output logic [3:0] x,
   output logic [3:0] y,
   output logic [2:0] obj_code
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IW    = $clog2(CELLS);

   typedef enum logic [1:0] {INIT, SCAN, DRAW} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              x_nxt, y_nxt, x_adv, y_adv;
   logic [2:0]              obj_nxt, cur_code, map_rd;
   logic [CELLS-1:0][2:0]   map_mem;
   logic [IW-1:0]           idx;
   logic                    mode_prev, go_prev, mode_rise, go_rise;
   logic                    advance, map_we, last_col, last_row;

   assign mode_rise = mode_pb & ~mode_prev;
   assign go_rise   = GameOver & ~go_prev;

   // Priority head > body > apple > border.
   always_comb begin
      cur_code = 3'd0;
      if (snakeHead)      cur_code = 3'd2;
      else if (snakeBody) cur_code = 3'd1;
      else if (apple)     cur_code = 3'd3;
      else if (border)    cur_code = 3'd4;
   end

   assign idx    = IW'(y) * IW'(GRID_W) + IW'(x);
   assign map_rd = map_mem[idx];

   assign last_col = (x == 4'(GRID_W - 1));
   assign last_row = (y == 4'(GRID_H - 1));

   always_comb begin
      x_adv = last_col ? 4'd0 : x + 4'd1;
      y_adv = y;
      if (last_col) y_adv = last_row ? 4'd0 : y + 4'd1;
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      obj_nxt   = obj_code;
      advance   = 1'b0;
      map_we    = 1'b0;
      case (state)
         INIT: if (cmd_done) state_nxt = SCAN;
         SCAN: begin
            if (cur_code == map_rd) begin
               advance = 1'b1;
            end else begin
               obj_nxt   = cur_code;
               state_nxt = DRAW;
            end
         end
         DRAW: begin
            if (cmd_done) begin
               map_we    = 1'b1;
               advance   = 1'b1;
               state_nxt = SCAN;
            end
         end
         default: state_nxt = INIT;
      endcase
      if (advance) begin
         x_nxt = x_adv;
         y_nxt = y_adv;
      end
      // Game over restarts the scan from the origin over a blank map, overriding all else.
      if (go_rise) begin
         state_nxt = SCAN;
         x_nxt     = 4'd0;
         y_nxt     = 4'd0;
         obj_nxt   = obj_code;
         advance   = 1'b0;
         map_we    = 1'b0;
      end
   end

   assign enable_loop = (state != INIT);
   assign diff        = (state == DRAW);
   assign init_cycle  = (state == INIT);
   assign en_update   = advance & last_col & last_row;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state      <= INIT;
         x          <= 4'd0;
         y          <= 4'd0;
         obj_code   <= 3'd0;
         mode_prev  <= 1'b0;
         go_prev    <= 1'b0;
         sync_reset <= 1'b0;
         map_mem    <= '0;
      end else begin
         state      <= state_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
         obj_code   <= obj_nxt;
         mode_prev  <= mode_pb;
         go_prev    <= GameOver;
         sync_reset <= go_rise;
         if (go_rise) begin
            map_mem <= '0;
         end else begin
            // A draw completing alongside invalidation must survive it, so it is written last.
            if (mode_rise) map_mem <= '1;
            if (map_we)    map_mem[idx] <= obj_code;
         end
      end
   end

endmodule

// File: tb/tb_snake_frame_scanner.sv
// Bench for snake_frame_scanner: a cell-indexed reference model checked every cycle,
// directed frames with hand-counted draw totals, then randomized traffic.
module tb_snake_frame_scanner;

   localparam int W = 16;
   localparam int H = 12;
   localparam int N = W * H;

   logic tb_clk = 1'b0;
   logic nrst, snakeBody, snakeHead, apple, border, mode_pb, GameOver, cmd_done;
   logic enable_loop, diff, init_cycle, en_update, sync_reset;
   logic [3:0] x, y;
   logic [2:0] obj_code;

   always #5 tb_clk = ~tb_clk;

   snake_frame_scanner #(.GRID_W(W), .GRID_H(H)) dut (
      .clk(tb_clk), .nrst(nrst), .snakeBody(snakeBody), .snakeHead(snakeHead),
      .apple(apple), .border(border), .mode_pb(mode_pb), .GameOver(GameOver),
      .cmd_done(cmd_done), .enable_loop(enable_loop), .diff(diff),
      .init_cycle(init_cycle), .en_update(en_update), .sync_reset(sync_reset),
      .x(x), .y(y), .obj_code(obj_code)
   );

   // scene seen by the "game logic", indexed by linear cell number y*W+x
   bit sc_body[N], sc_head[N], sc_apple[N], sc_border[N];

   // reference model: mode 0 = waiting for display init, 1 = scanning, 2 = drawing
   int m_mode, m_pos, m_obj;
   int m_map[N];
   bit m_md_prev, m_go_prev, m_sync;

   int total = 0, bad = 0;
   int n_diff = 0, n_upd = 0, n_sync = 0, n_hit44 = 0, n_hit74 = 0;
   int n_code[8];
   int first_x = -1, first_y = -1, first_code = -1;
   bit diff_q = 1'b0;

   // stimulus controls
   bit rst_lvl, auto_ack, rand_ack, force_done, go_lvl, md_force;
   int ack_delay = 5, dwell = 0, md_at_pos = -1;

   function automatic int enc(bit b, bit h, bit a, bit r);
      if (h) return 2;
      if (b) return 1;
      if (a) return 3;
      if (r) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_obj = 0;
      m_md_prev = 0; m_go_prev = 0; m_sync = 0;
      foreach (m_map[i]) m_map[i] = 0;
   endtask

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // compare process: outputs are stable at the falling edge
   always @(negedge tb_clk) begin
      int code, wpos;
      bit go_rise, md_rise, adv;
      logic [15:0] exp_v, got_v;
      if (nrst) model_reset();
      code    = enc(snakeBody, snakeHead, apple, border);
      go_rise = GameOver && !m_go_prev;
      md_rise = mode_pb && !m_md_prev;
      adv = !nrst && !go_rise &&
            ((m_mode == 1 && code == m_map[m_pos]) || (m_mode == 2 && cmd_done));
      exp_v = {(m_mode != 0), (m_mode == 2), (m_mode == 0), (adv && m_pos == N - 1), m_sync,
               4'(m_pos % W), 4'(m_pos / W), 3'(m_obj)};
      got_v = {enable_loop, diff, init_cycle, en_update, sync_reset, x, y, obj_code};
      total++;
      if (got_v !== exp_v) begin
         bad++;
         $display("FAIL cycle t=%0t got loop=%b diff=%b init=%b upd=%b sync=%b x=%0d y=%0d obj=%0d want loop=%b diff=%b init=%b upd=%b sync=%b x=%0d y=%0d obj=%0d",
                  $time, got_v[15], got_v[14], got_v[13], got_v[12], got_v[11], got_v[10:7], got_v[6:3], got_v[2:0],
                  exp_v[15], exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:3], exp_v[2:0]);
      end
      if (!nrst && diff === 1'b1 && !diff_q) begin
         n_diff++;
         n_code[int'(obj_code)]++;
         if (x == 4 && y == 4 && obj_code == 2) n_hit44++;
         if (x == 7 && y == 4 && obj_code == 3) n_hit74++;
         if (first_x < 0) begin first_x = x; first_y = y; first_code = obj_code; end
      end
      diff_q = (diff === 1'b1);
      if (en_update === 1'b1) n_upd++;
      if (sync_reset === 1'b1) n_sync++;
      if (!nrst) begin
         m_sync = go_rise;
         if (go_rise) begin
            foreach (m_map[i]) m_map[i] = 0;
            m_pos = 0; m_mode = 1;
         end else begin
            wpos = -1;
            case (m_mode)
               0: if (cmd_done) m_mode = 1;
               1: if (code == m_map[m_pos]) m_pos = (m_pos + 1) % N;
                  else begin m_obj = code; m_mode = 2; end
               default: if (cmd_done) begin wpos = m_pos; m_pos = (m_pos + 1) % N; m_mode = 1; end
            endcase
            if (md_rise) foreach (m_map[i]) m_map[i] = 7;
            if (wpos >= 0) m_map[wpos] = m_obj;
         end
         m_md_prev = mode_pb;
         m_go_prev = GameOver;
      end
   end

   // drive one cycle of inputs just after the rising edge, from the model's current cell
   task automatic drive_cycle();
      int p;
      @(posedge tb_clk); #2;
      nrst = rst_lvl;
      p = m_pos;
      snakeBody = sc_body[p]; snakeHead = sc_head[p];
      apple = sc_apple[p];    border = sc_border[p];
      if (m_mode == 2) dwell++; else dwell = 0;
      if (rand_ack && dwell == 1) ack_delay = $urandom_range(0, 6);
      cmd_done = force_done || (auto_ack && m_mode == 2 && dwell == ack_delay + 1);
      mode_pb  = md_force || (m_pos == md_at_pos);
      GameOver = go_lvl;
   endtask

   task automatic step();
      drive_cycle();
      @(negedge tb_clk); #1;
   endtask

   task automatic wait_upd(input int bound, input string name);
      int s;
      s = n_upd;
      for (int i = 0; i < bound; i++) begin
         step();
         if (n_upd != s) return;
      end
      check({name, "_timeout"}, 1, 0);
   endtask

   initial begin
      int s_diff, s_upd, s_sync, s_c0, s_c2, s_c3, s_c4, s_h44, s_h74, c;
      bit ok;
      nrst = 1; snakeBody = 0; snakeHead = 0; apple = 0; border = 0;
      mode_pb = 0; GameOver = 0; cmd_done = 0;
      rst_lvl = 1; auto_ack = 0; rand_ack = 0; force_done = 0; go_lvl = 0; md_force = 0;
      foreach (n_code[i]) n_code[i] = 0;
      model_reset();

      // reset, then idle in init with no cmd_done
      step(); step();
      rst_lvl = 0;
      repeat (50) step();
      check("init_x", int'(x), 0);
      check("init_y", int'(y), 0);
      check("init_cycle", int'(init_cycle), 1);
      check("init_enable_loop", int'(enable_loop), 0);
      check("init_diff", int'(diff), 0);

      // frame A: border ring, head at (4,4), apple at (7,4)
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            sc_border[yy * W + xx] = (xx == 0 || xx == W - 1 || yy == 0 || yy == H - 1);
      sc_head[4 * W + 4] = 1;
      sc_apple[4 * W + 7] = 1;
      auto_ack = 1; ack_delay = 5;
      force_done = 1; step(); force_done = 0;
      s_diff = n_diff; s_upd = n_upd; s_c2 = n_code[2]; s_c3 = n_code[3]; s_c4 = n_code[4];
      wait_upd(3000, "frameA");
      check("frameA_diffs", n_diff - s_diff, 54);
      check("frameA_border", n_code[4] - s_c4, 52);
      check("frameA_head", n_code[2] - s_c2, 1);
      check("frameA_apple", n_code[3] - s_c3, 1);
      check("frameA_at44", n_hit44, 1);
      check("frameA_at74", n_hit74, 1);
      check("frameA_upd", n_upd - s_upd, 1);
      check("first_diff_x", first_x, 0);
      check("first_diff_y", first_y, 0);
      check("first_diff_code", first_code, 4);

      // identical frame twice: nothing to draw, one frame per 192 cycles
      s_diff = n_diff; s_upd = n_upd;
      repeat (2 * N) step();
      check("steady_diffs", n_diff - s_diff, 0);
      check("steady_upd", n_upd - s_upd, 2);

      // mode_pb on the last cell: the following frame redraws every cell
      md_at_pos = N - 1;
      wait_upd(400, "mode_arm");
      md_at_pos = -1;
      s_diff = n_diff; s_c0 = n_code[0]; s_c2 = n_code[2]; s_c3 = n_code[3]; s_c4 = n_code[4];
      wait_upd(3000, "redraw");
      check("redraw_diffs", n_diff - s_diff, N);
      check("redraw_empty", n_code[0] - s_c0, N - 54);
      check("redraw_border", n_code[4] - s_c4, 52);
      check("redraw_head", n_code[2] - s_c2, 1);
      check("redraw_apple", n_code[3] - s_c3, 1);

      // game over mid-scan
      repeat (100) step();
      s_diff = n_diff; s_sync = n_sync; s_upd = n_upd;
      go_lvl = 1; step();
      step();
      check("go_x", int'(x), 0);
      check("go_y", int'(y), 0);
      check("go_sync", int'(sync_reset), 1);
      repeat (3) step();
      go_lvl = 0;
      check("go_sync_once", n_sync - s_sync, 1);
      wait_upd(3000, "after_go");
      check("after_go_diffs", n_diff - s_diff, 54);

      // head and border together; hold the draw
      sc_head[6 * W + 9] = 1; sc_border[6 * W + 9] = 1;
      auto_ack = 0;
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin step(); ok = (diff === 1'b1); end
      check("hold_reached", int'(ok), 1);
      check("hold_code", int'(obj_code), 2);
      check("hold_x", int'(x), 9);
      check("hold_y", int'(y), 6);
      for (int i = 0; i < 20; i++) begin
         step();
         check("hold_stable", {diff, x, y, obj_code}, {1'b1, 4'd9, 4'd6, 3'd2});
      end
      force_done = 1; step(); force_done = 0;
      step();
      check("hold_release", int'(diff), 0);
      auto_ack = 1;

      // randomized traffic against the model
      rand_ack = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 5) begin
            c = $urandom_range(0, N - 1);
            sc_body[c] = ($urandom_range(0, 3) == 0); sc_head[c] = ($urandom_range(0, 7) == 0);
            sc_apple[c] = ($urandom_range(0, 5) == 0); sc_border[c] = ($urandom_range(0, 3) == 0);
         end
         md_force   = ($urandom_range(0, 99) < 2);
         force_done = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 2) go_lvl = !go_lvl;
         rst_lvl    = ($urandom_range(0, 999) < 3);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
